// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants (S-box, Rcon, sizes) and key-schedule FSM state.
package aes_pkg;
   localparam int AES_KEY_W  = 128;
   localparam int AES_NUM_RK = 11;
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_e;
   localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };
endpackage

// File: rtl/key_expand_round.sv
// key_expand_round: one combinational AES-128 key-expansion step, rk[round-1] -> rk[round].
module key_expand_round
   import aes_pkg::*;
(
   input  logic [AES_KEY_W-1:0] prev_key,
   input  logic [3:0]           round,
   output logic [AES_KEY_W-1:0] next_key
);
   logic [31:0] rot, sub, w0, w1, w2, w3;
   logic [7:0]  rc;
   assign rot = {prev_key[23:0], prev_key[31:24]};
   for (genvar i = 0; i < 4; i++) begin : g_sub
      assign sub[8*i +: 8] = SBOX[rot[8*i +: 8]];
   end
   assign rc = (round == 4'd0 || round > 4'd10) ? 8'h00 : RCON[round - 4'd1];
   assign w0 = prev_key[127:96] ^ sub ^ {rc, 24'h0};
   assign w1 = prev_key[95:64] ^ w0;
   assign w2 = prev_key[63:32] ^ w1;
   assign w3 = prev_key[31:0] ^ w2;
   assign next_key = {w0, w1, w2, w3};
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: iterative AES-128 key schedule filling an 11-entry round-key store.
// Define KEY_SCHED_ZEROIZE_EN to add a single-cycle zeroize input.
module aes_key_sched_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_RK = AES_NUM_RK
)(
   input  logic                 clk,
   input  logic                 rst,
`ifdef KEY_SCHED_ZEROIZE_EN
   input  logic                 zeroize,
`endif
   input  logic                 start,
   input  logic [AES_KEY_W-1:0] key_in,
   output logic                 busy,
   output logic                 keys_ready,
   input  logic                 rd_en,
   input  logic [3:0]           rd_idx,
   output logic [AES_KEY_W-1:0] rd_key,
   output logic                 rd_valid
);
   localparam logic [3:0] LAST = 4'(NUM_RK - 1);
   ks_state_e state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [AES_KEY_W-1:0] rk_q [NUM_RK];
   logic [AES_KEY_W-1:0] rd_key_q, prev_key, next_key;
   logic rd_valid_q, ld, wr, clr;
`ifdef KEY_SCHED_ZEROIZE_EN
   assign clr = rst | zeroize;
`else
   assign clr = rst;
`endif
   assign prev_key = (round_q == 4'd0 || round_q > LAST) ? '0 : rk_q[round_q - 4'd1];
   key_expand_round u_round (
      .prev_key(prev_key),
      .round   (round_q),
      .next_key(next_key)
   );
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      ld = 1'b0;
      wr = 1'b0;
      case (state_q)
         EXPAND: begin
            wr = 1'b1;
            round_d = (round_q == LAST) ? round_q : round_q + 4'd1;
            state_d = (round_q == LAST) ? DONE : EXPAND;
         end
         default: begin
            ld = start;
            round_d = start ? 4'd1 : round_q;
            state_d = start ? EXPAND : state_q;
         end
      endcase
   end
   // A read racing a write to the same entry sees the pre-edge contents.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         round_q <= '0;
         rd_key_q <= '0;
         for (int k = 0; k < NUM_RK; k++) rk_q[k] <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         if (ld) rk_q[0] <= key_in;
         if (wr) rk_q[round_q] <= next_key;
         if (rd_en) rd_key_q <= (rd_idx <= LAST) ? rk_q[rd_idx] : '0;
      end
      rd_valid_q <= rst ? 1'b0 : rd_en;
   end
   assign busy = state_q == EXPAND;
   assign keys_ready = state_q == DONE;
   assign rd_key = rd_key_q;
   assign rd_valid = rd_valid_q;
endmodule
